// File: rtl/dmem_responder_pkg.sv
// Shared memop encodings, MMIO register map and the write-lane payload for the dmem responder.
package dmem_responder_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_LANES = XLEN / 8;

  // memop = funct3, shared with the core's control generator
  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  // MMIO register select, addr[3:2] inside the MMIO window
  typedef enum logic [1:0] {
    MMIO_CYCLE  = 2'd0,
    MMIO_DBG    = 2'd1,
    MMIO_STATUS = 2'd2,
    MMIO_RSVD   = 2'd3
  } mmio_reg_e;

  // Lane-replicated store payload with per-byte enables
  typedef struct packed {
    logic [NUM_LANES-1:0] be;
    logic [XLEN-1:0]      data;
  } wr_req_t;

  // Replace the enabled bytes of old_word with those of new_word
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]      old_word,
                                                  input logic [XLEN-1:0]      new_word,
                                                  input logic [NUM_LANES-1:0] be);
    logic [XLEN-1:0] r;
    r = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_mem_align.sv
// Combinational lane steering: store byte enables/replication, load select/extend, misalign detect.
module dmem_responder_mem_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] datain,
  input  logic [XLEN-1:0] raw_word,
  output wr_req_t         wr_c,
  output logic            misalign_c,
  output logic [XLEN-1:0] rdata_c
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // op[1:0] gives the access size, op[2] selects zero extension; misaligned accesses align down
  always_comb begin
    misalign_c = 1'b0;
    wr_c.be    = 4'hF;
    wr_c.data  = datain;
    rdata_c    = raw_word;
    sel_byte   = 8'h00;
    sel_half   = 16'h0000;
    case (op[1:0])
      2'b00: begin
        wr_c.be   = 4'b0001 << offset;
        wr_c.data = {4{datain[7:0]}};
        sel_byte  = raw_word[{offset, 3'b000} +: 8];
        rdata_c   = op[2] ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      2'b01: begin
        misalign_c = offset[0];
        wr_c.be    = 4'b0011 << {offset[1], 1'b0};
        wr_c.data  = {2{datain[15:0]}};
        sel_half   = offset[1] ? raw_word[31:16] : raw_word[15:0];
        rdata_c    = op[2] ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      2'b10: begin
        misalign_c = !op[2] && (offset != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte enables, MMIO window (cycle, debug, status), 1-cycle loads.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [3:0]  MMIO_TAG   = 4'hF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic [2:0]  op,
  input  logic        we,
  output logic [31:0] dataout,
  output logic [31:0] dbg_reg,
  output logic        misalign
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [XLEN-1:0]       mem [DEPTH];
  logic [XLEN-1:0]       cycle_cnt;
  logic                  is_mmio_c;
  mmio_reg_e             mmio_sel_c;
  logic [ADDR_WIDTH-1:0] word_idx_c;
  logic [XLEN-1:0]       raw_word_c;
  logic [XLEN-1:0]       rdata_c;
  wr_req_t               wr_c;
  logic                  misalign_c;
  logic                  dbg_we_c;
  logic                  status_clr_c;
  logic                  unused_c;

  assign is_mmio_c    = (addr[31:28] == MMIO_TAG);
  assign mmio_sel_c   = mmio_reg_e'(addr[3:2]);
  assign word_idx_c   = addr[ADDR_WIDTH+1:2];
  assign dbg_we_c     = we && is_mmio_c && (mmio_sel_c == MMIO_DBG);
  assign status_clr_c = we && is_mmio_c && (mmio_sel_c == MMIO_STATUS) && datain[0];
  // Address bits between the RAM index and the MMIO tag alias
  assign unused_c     = &{1'b0, addr[27:ADDR_WIDTH+2]};

  dmem_responder_mem_align u_align (
    .op         (op),
    .offset     (addr[1:0]),
    .datain     (datain),
    .raw_word   (raw_word_c),
    .wr_c       (wr_c),
    .misalign_c (misalign_c),
    .rdata_c    (rdata_c)
  );

  // Source word for the load path: RAM word or MMIO register
  always_comb begin
    raw_word_c = mem[word_idx_c];
    if (is_mmio_c) begin
      case (mmio_sel_c)
        MMIO_CYCLE:  raw_word_c = cycle_cnt;
        MMIO_DBG:    raw_word_c = dbg_reg;
        MMIO_STATUS: raw_word_c = {(XLEN-1)'(0), misalign};
        default:     raw_word_c = '0;
      endcase
    end
  end

  // RAM byte-lane write; a store coinciding with reset is dropped, contents survive reset
  always_ff @(posedge clk) begin
    if (we && !is_mmio_c && !clr) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (wr_c.be[b]) mem[word_idx_c][8*b +: 8] <= wr_c.data[8*b +: 8];
      end
    end
  end

  // Load result, cycle counter, debug register and sticky misalign (set wins over W1C)
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dataout   <= '0;
      dbg_reg   <= '0;
      misalign  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      dataout   <= rdata_c;
      cycle_cnt <= cycle_cnt + XLEN'(1);
      if (dbg_we_c) dbg_reg <= merge_bytes(dbg_reg, wr_c.data, wr_c.be);
      misalign  <= misalign_c | (misalign & ~status_clr_c);
    end
  end

endmodule
